// File: rtl/peripheral_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_pipelined_adder
// Brief    : Pipelined add/subtract unit. The carry chain is split into STAGES
//            registered segments, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_pipelined_adder #(
    parameter int WIDTH  = 32,  // must be divisible by STAGES
    parameter int STAGES = 2,   // >= 1
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               cin,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic               ovf,
    output logic [TAG_W-1:0]   tag_out
);

    localparam int C_SEG  = WIDTH / STAGES;
    localparam int C_LAST = STAGES - 1;

    // Stage registers: operands travel with the partial sum so later stages
    // can resolve their own segment.
    logic               r_v   [STAGES];
    logic               r_op  [STAGES];
    logic               r_c   [STAGES];
    logic [WIDTH-1:0]   r_x   [STAGES];
    logic [WIDTH-1:0]   r_y   [STAGES];
    logic [WIDTH-1:0]   r_s   [STAGES];
    logic [TAG_W-1:0]   r_tag [STAGES];
    logic               r_cout;
    logic               r_ovf;

    logic               w_load [STAGES];
    logic               w_sv   [STAGES];
    logic               w_sop  [STAGES];
    logic               w_sc   [STAGES];
    logic [WIDTH-1:0]   w_sx   [STAGES];
    logic [WIDTH-1:0]   w_sy   [STAGES];
    logic [WIDTH-1:0]   w_ss   [STAGES];
    logic [TAG_W-1:0]   w_stag [STAGES];
    logic [C_SEG:0]     w_seg  [STAGES];
    logic [WIDTH-1:0]   w_ns   [STAGES];
    logic               w_c_msb;
    logic               w_c_out;

    always_comb begin
        // Subtract is folded into the operands so every stage is a plain adder.
        w_sv[0]   = in_valid;
        w_sop[0]  = op;
        w_sx[0]   = x;
        w_sy[0]   = op ? ~y : y;
        w_sc[0]   = op ? ~cin : cin;
        w_ss[0]   = '0;
        w_stag[0] = tag_in;
        for (int k = 1; k < STAGES; k++) begin
            w_sv[k]   = r_v[k-1];
            w_sop[k]  = r_op[k-1];
            w_sx[k]   = r_x[k-1];
            w_sy[k]   = r_y[k-1];
            w_sc[k]   = r_c[k-1];
            w_ss[k]   = r_s[k-1];
            w_stag[k] = r_tag[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, w_sx[k][k*C_SEG +: C_SEG]}
                     + {1'b0, w_sy[k][k*C_SEG +: C_SEG]}
                     + {{C_SEG{1'b0}}, w_sc[k]};
            w_ns[k] = w_ss[k];
            w_ns[k][k*C_SEG +: C_SEG] = w_seg[k][C_SEG-1:0];
        end
        // A stage may load when empty or when its successor drains it.
        w_load[C_LAST] = ~r_v[C_LAST] | out_ready;
        for (int k = C_LAST - 1; k >= 0; k--) begin
            w_load[k] = ~r_v[k] | w_load[k+1];
        end
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        w_c_msb = w_seg[C_LAST][C_SEG-1] ^ w_sx[C_LAST][WIDTH-1] ^ w_sy[C_LAST][WIDTH-1];
        w_c_out = w_seg[C_LAST][C_SEG];
    end

    assign in_ready = w_load[0] & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= 1'b0;
                r_op[k]  <= 1'b0;
                r_c[k]   <= 1'b0;
                r_x[k]   <= '0;
                r_y[k]   <= '0;
                r_s[k]   <= '0;
                r_tag[k] <= '0;
            end
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_sv[k];
                    if (w_sv[k]) begin
                        r_op[k]  <= w_sop[k];
                        r_c[k]   <= w_seg[k][C_SEG];
                        r_x[k]   <= w_sx[k];
                        r_y[k]   <= w_sy[k];
                        r_s[k]   <= w_ns[k];
                        r_tag[k] <= w_stag[k];
                    end
                end
            end
            if (w_load[C_LAST] && w_sv[C_LAST]) begin
                r_cout <= w_c_out ^ w_sop[C_LAST];
                r_ovf  <= w_c_msb ^ w_c_out;
            end
        end
    end

    assign out_valid = r_v[C_LAST];
    assign sum       = r_s[C_LAST];
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign tag_out   = r_tag[C_LAST];

endmodule
`default_nettype wire

// File: tb/tb_peripheral_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_pipelined_adder
// Brief    : Directed 8-bit checks plus random traffic on 32-bit units with
//            STAGES 1/2/4, scored against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_pipelined_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    int n_total = 0;
    int n_bad   = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the operand width.
    function automatic exp_t model(input int w, input logic op_i, input longint xa,
                                   input longint ya, input logic ci, input logic [3:0] tg);
        exp_t   e;
        longint m, half, r, sx, sy, sr;
        m    = longint'(1) << w;
        half = m / 2;
        r    = op_i ? (xa - ya - longint'(ci)) : (xa + ya + longint'(ci));
        e.sum  = 32'(r & (m - 1));
        e.cout = op_i ? (r < 0) : (r >= m);
        sx = (xa >= half) ? xa - m : xa;
        sy = (ya >= half) ? ya - m : ya;
        sr = op_i ? (sx - sy - longint'(ci)) : (sx + sy + longint'(ci));
        e.ovf = (sr < -half) || (sr >= half);
        e.tag = tg;
        return e;
    endfunction

    // ---------------- 8-bit, 2-stage unit for directed checks ----------------
    logic       dv, dop, dcin, dir, dordy, dov, dcout, dovf;
    logic [7:0] dx, dy, dsum;
    logic [3:0] dtag, dtago;
    exp_t       q8[$];

    peripheral_pipelined_adder #(.WIDTH(8), .STAGES(2), .TAG_W(4)) u_dut8 (
        .clk(clk), .reset(rst), .in_valid(dv), .in_ready(dir), .op(dop),
        .x(dx), .y(dy), .cin(dcin), .tag_in(dtag), .out_valid(dov),
        .out_ready(dordy), .sum(dsum), .cout(dcout), .ovf(dovf), .tag_out(dtago)
    );

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
        end else begin
            if (dov && dordy) begin
                check("d8_out_expected", longint'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    exp_t e;
                    e = q8.pop_front();
                    check("d8_sum", longint'(dsum), longint'(e.sum));
                    check("d8_cout", longint'(dcout), longint'(e.cout));
                    check("d8_ovf", longint'(dovf), longint'(e.ovf));
                    check("d8_tag", longint'(dtago), longint'(e.tag));
                end
            end
            if (dv && dir)
                q8.push_back(model(8, dop, longint'(dx), longint'(dy), dcin, dtag));
        end
    end

    // ---------------- 32-bit units, STAGES = 1, 2, 4 ----------------
    logic        rv, rop, rcin, rordy;
    logic [31:0] rx, ry;
    logic [3:0]  rtag;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_rand
        localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        logic        rdy, ov, co, of;
        logic [31:0] s;
        logic [3:0]  t;
        exp_t        q[$];

        peripheral_pipelined_adder #(.WIDTH(32), .STAGES(ST), .TAG_W(4)) u_dut (
            .clk(clk), .reset(rst), .in_valid(rv), .in_ready(rdy), .op(rop),
            .x(rx), .y(ry), .cin(rcin), .tag_in(rtag), .out_valid(ov),
            .out_ready(rordy), .sum(s), .cout(co), .ovf(of), .tag_out(t)
        );

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                if (ov && rordy) begin
                    check($sformatf("r%0d_out_expected", ST), longint'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        exp_t e;
                        e = q.pop_front();
                        check($sformatf("r%0d_sum", ST), longint'(s), longint'(e.sum));
                        check($sformatf("r%0d_cout", ST), longint'(co), longint'(e.cout));
                        check($sformatf("r%0d_ovf", ST), longint'(of), longint'(e.ovf));
                        check($sformatf("r%0d_tag", ST), longint'(t), longint'(e.tag));
                    end
                end
                if (rv && rdy)
                    q.push_back(model(32, rop, longint'(rx), longint'(ry), rcin, rtag));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat and returns just after the edge that accepted it.
    task automatic send8(input logic o, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [3:0] tg);
        int n;
        dop = o; dx = a; dy = b; dcin = c; dtag = tg; dv = 1'b1;
        n = 0;
        @(negedge clk);
        while (!dir && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("send_ready", longint'(dir), 1);
        tick();
        dv = 1'b0;
    endtask

    task automatic vec8(input string name, input logic o, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic [7:0] es,
                        input logic ec, input logic eo);
        send8(o, a, b, c, 4'hA);
        @(negedge clk);
        check({name, "_early"}, longint'(dov), 0);
        tick();
        @(negedge clk);
        check({name, "_valid"}, longint'(dov), 1);
        check({name, "_sum"}, longint'(dsum), longint'(es));
        check({name, "_cout"}, longint'(dcout), longint'(ec));
        check({name, "_ovf"}, longint'(dovf), longint'(eo));
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int         sent, nvalid;
        logic       acc;
        logic [7:0] s_sum;
        logic [3:0] s_tag;

        rst = 1'b1;
        dv = 0; dop = 0; dx = 0; dy = 0; dcin = 0; dtag = 0; dordy = 1'b1;
        rv = 0; rop = 0; rx = 0; ry = 0; rcin = 0; rtag = 0; rordy = 1'b1;

        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", longint'(dir), 0);
        check("rst_out_valid", longint'(dov), 0);
        check("rst_sum", longint'(dsum), 0);
        check("rst_cout", longint'(dcout), 0);
        check("rst_ovf", longint'(dovf), 0);
        check("rst_tag", longint'(dtago), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(dir), 1);
        tick();

        vec8("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        vec8("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        vec8("add_0f_01", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        vec8("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0);
        vec8("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        vec8("add_cin",   1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

        // Stream six tagged beats into a stalled output.
        dordy = 1'b0;
        sent  = 0;
        dtag  = 4'd0; dx = 8'($urandom); dy = 8'($urandom);
        dop   = 1'($urandom); dcin = 1'($urandom); dv = 1'b1;
        s_sum = '0; s_tag = '0;
        for (int c = 0; c < 40 && sent < 6; c++) begin
            if (c == 4) dordy = 1'b1;
            @(negedge clk);
            if (c == 2 || c == 3) begin
                check("stall_in_ready", longint'(dir), 0);
                check("stall_out_valid", longint'(dov), 1);
            end
            if (c == 2) begin
                s_sum = dsum;
                s_tag = dtago;
            end
            if (c == 3) begin
                check("stall_sum_stable", longint'(dsum), longint'(s_sum));
                check("stall_tag_stable", longint'(dtago), longint'(s_tag));
            end
            if (c == 4) check("release_pass_through", longint'(dir), 1);
            acc = dv && dir;
            tick();
            if (acc) begin
                sent++;
                if (sent < 6) begin
                    dtag = 4'(sent); dx = 8'($urandom); dy = 8'($urandom);
                    dop = 1'($urandom); dcin = 1'($urandom);
                end else begin
                    dv = 1'b0;
                end
            end
        end
        check("stall_sent", longint'(sent), 6);
        repeat (6) tick();
        @(negedge clk);
        check("stall_drained", longint'(q8.size()), 0);
        tick();

        // Reset with two beats in flight.
        dordy = 1'b0;
        send8(1'b0, 8'h11, 8'h22, 1'b0, 4'h7);
        send8(1'b1, 8'h33, 8'h01, 1'b0, 4'h8);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", longint'(dir), 0);
        tick();
        rst = 1'b0;
        dordy = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", longint'(dov), 0);
        check("mid_rst_ready_after", longint'(dir), 1);
        nvalid = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clk);
            if (dov) nvalid++;
        end
        check("mid_rst_no_stale", longint'(nvalid), 0);
        tick();

        // Random traffic on the 32-bit units.
        for (int c = 0; c < 14000; c++) begin
            rv    = ($urandom_range(0, 3) != 0);
            rx    = $urandom;
            ry    = $urandom;
            rop   = 1'($urandom);
            rcin  = 1'($urandom);
            rtag  = 4'($urandom);
            rordy = ($urandom_range(0, 3) != 0);
            tick();
        end
        rv = 1'b0;
        rordy = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("r1_drained", longint'(g_rand[0].q.size()), 0);
        check("r2_drained", longint'(g_rand[1].q.size()), 0);
        check("r4_drained", longint'(g_rand[2].q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/peripheral_pipelined_adder.md
# peripheral_pipelined_adder

Parametrised, pipelined add/subtract unit with a valid/ready handshake on both sides, replacing the fixed 4-bit combinational adder in the peripheral verification library. The carry chain is split into `STAGES` registered segments so wide operands close timing at one result per cycle. A user tag travels with each operation. It sits behind a driver/monitor interface pair: the driver side pushes operands and the monitor side samples results.

## Interface
- `WIDTH`, 32: operand and result width; must be divisible by `STAGES`.
- `STAGES`, 2: number of pipeline stages, ≥1; each stage resolves `WIDTH/STAGES` bits of the carry chain.
- `TAG_W`, 4: width of the user tag carried alongside each operation.
- `clk`  in  1  single clock; all logic is clocked on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  unit can accept a beat this cycle.
- `op`  in  1  0 = add (x+y+cin), 1 = subtract (x−y−cin).
- `x`, `y`  in  WIDTH  operands, unsigned/two's-complement agnostic.
- `cin`  in  1  carry-in (add) / borrow-in (subtract).
- `tag_in`  in  TAG_W  user tag.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry-out (add) / borrow-out (subtract).
- `ovf`  out  1  signed overflow.
- `tag_out`  out  TAG_W  tag of the current result.

## Operation
- Effective operands: add uses `y_e = y`, `c_e = cin`; subtract uses `y_e = ~y`, `c_e = ~cin`. The core always computes `x + y_e + c_e`.
- Stage k (0-based) adds bits [k·S+S−1 : k·S], with S = WIDTH/STAGES, using the carry registered from stage k−1. Stage 0 uses `c_e`.
- Unprocessed upper operand bits and already-computed lower sum bits are carried forward in the stage registers, together with `op`, `tag` and the carry.
- Final carry `c_out` comes from the MSB segment. `cout = c_out` for add and `~c_out` for subtract (borrow).
- `ovf` = carry into MSB XOR carry out of MSB, computed in the last stage. This is valid for both ops and is independent of `cout`.
- Each stage holds a valid bit. Stage k loads when it is empty, or when stage k+1 loads (for the last stage, when the output is accepted, i.e. `out_valid & out_ready`).
- Bubbles collapse: an empty middle stage accepts even while the output is stalled.
- `in_ready` = stage 0 will load this cycle. It is combinational from the valid bits and `out_ready`, and forced to 0 while `reset` is high.
- Input beat is accepted on `in_valid & in_ready`. Result is consumed on `out_valid & out_ready`.
- Ordering is strictly FIFO. There is no reordering or drop. Capacity is `STAGES` beats.
- `out_valid` and the result fields are the last-stage registers.
- Outputs hold stable while `out_valid & ~out_ready`.

## Timing
- Reset (sampled high at a rising edge): all valid bits cleared.
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, `tag_out`=0 from the next cycle.
  - `in_ready`=0 while `reset` is high; `in_ready`=1 in the first cycle after reset deasserts.
- Latency: a beat accepted at edge T appears with `out_valid`=1 after edge T+STAGES−1, i.e. on the cycle following the STAGES-th edge. With `out_ready` held high: latency = STAGES cycles, throughput 1 beat/cycle.
- Full pipeline with output stalled: `in_ready`=0. Releasing `out_ready` re-enables `in_ready` in the same cycle (pass-through).
- Simultaneous output accept and input accept when full: both occur, and occupancy is unchanged.
- Reset mid-operation discards all in-flight beats. No partial result is ever presented.
- `STAGES`=1 degenerates to a single registered adder with the same handshake.

## Test plan
- WIDTH=8, STAGES=2, add 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0, `out_valid` 2 cycles after accept.
- Add 0x7F+0x01, cin=0 → sum=0x80, cout=0, ovf=1. Add 0x0F+0x01 → sum=0x10 (carry crosses the 4-bit stage boundary).
- Subtract 0x05−0x07, cin=0 → sum=0xFE, cout=1 (borrow), ovf=0. Subtract 0x80−0x01 → sum=0x7F, cout=0, ovf=1.
- Stream 6 beats with tags 0..5 while `out_ready`=0 for 4 cycles:
  - `in_ready` falls after 2 accepted beats.
  - Results emerge in tag order 0..5 with none lost or duplicated.
  - `sum`/`tag_out` stay stable during the stall.
- Assert `reset` for 1 cycle with 2 beats in flight → `out_valid`=0 next cycle, `in_ready`=0 during reset and 1 after. The pre-reset beats never appear.
- Random back-to-back traffic with random `out_ready`, WIDTH=32, STAGES∈{1,2,4}, checked against a reference model for `sum`/`cout`/`ovf`/`tag_out` → zero mismatches over 10k beats.
